// File: rtl/parking_pkg.sv
// Shared definitions for the parking gate controller.
//   gate_state_e  : controller FSM states
//   NUM_SLOTS     : slots in the pool, numbered 1..NUM_SLOTS (slot 0 is invalid)
//   slot_code()   : passcode issued for a slot
//   highest_free(): highest-numbered free slot, 0 when the pool is full
//   slot_mask()   : one-hot occupancy mask for a slot number
package parking_pkg;

  localparam int unsigned NUM_SLOTS = 7;

  typedef enum logic [1:0] {
    IDLE,
    EXIT_CHECK,
    GATE_OPEN
  } gate_state_e;

  // Running sum of the Fibonacci terms 1,2,3,5,8,13,21,34 up to term s+1.
  function automatic logic [7:0] slot_code(input logic [2:0] s);
    logic [7:0] c;
    case (s)
      3'd1:    c = 8'd3;
      3'd2:    c = 8'd6;
      3'd3:    c = 8'd11;
      3'd4:    c = 8'd19;
      3'd5:    c = 8'd32;
      3'd6:    c = 8'd53;
      3'd7:    c = 8'd87;
      default: c = 8'd0;
    endcase
    return c;
  endfunction

  // Ascending scan so the last free slot seen (the highest) wins.
  function automatic logic [2:0] highest_free(input logic [NUM_SLOTS:1] occ);
    logic [2:0] r;
    r = '0;
    for (int unsigned s = 1; s <= NUM_SLOTS; s++) begin
      if (!occ[s]) r = 3'(s);
    end
    return r;
  endfunction

  // Slot 0 maps to an empty mask, so it can never match an occupied bit.
  function automatic logic [NUM_SLOTS:1] slot_mask(input logic [2:0] s);
    logic [NUM_SLOTS:1] m;
    m = '0;
    for (int unsigned i = 1; i <= NUM_SLOTS; i++) begin
      if (3'(i) == s) m[i] = 1'b1;
    end
    return m;
  endfunction

endpackage

// File: rtl/parking_rr_arb.sv
// Round-robin arbiter for the entry lanes.
//   i_clk, i_rst : clock, synchronous active-high reset
//   i_req        : per-lane request levels
//   i_update     : a grant was taken this cycle; advance priority past the winner
//   o_gnt        : combinational one-hot winner (zero when no request)
//   o_any        : at least one lane is requesting
// r_ptr is the lane with highest priority; it resets to lane 0.
module parking_rr_arb #(
  parameter int unsigned N = 2
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic [N-1:0] i_req,
  input  logic         i_update,
  output logic [N-1:0] o_gnt,
  output logic         o_any
);

  localparam int unsigned PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] r_ptr;
  logic [PW-1:0] w_win;
  logic [PW-1:0] w_idx;

  always_comb begin
    o_gnt = '0;
    o_any = 1'b0;
    w_win = '0;
    w_idx = '0;
    for (int unsigned i = 0; i < N; i++) begin
      w_idx = PW'((32'(r_ptr) + i) % N);
      if (!o_any && i_req[w_idx]) begin
        o_any        = 1'b1;
        w_win        = w_idx;
        o_gnt[w_idx] = 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_ptr <= '0;
    end else if (i_update) begin
      r_ptr <= PW'((32'(w_win) + 1) % N);
    end
  end

endmodule

// File: rtl/parking_gate_ctrl.sv
// Parking barrier and slot-pool sequencer.
//   enable          : clock (rising edge)
//   gl_reset        : synchronous active-high reset
//   entry_req       : per-lane entry request, held until entry_gnt
//   exit_req        : exit request, held until exit_ack
//   exit_from       : slot being vacated (1..7)
//   exit_code       : passcode keyed at exit
//   entry_gnt       : one-hot, one-cycle grant pulse
//   slot_id         : slot allocated with the latest grant
//   pass_code       : passcode for slot_id, held until the next grant
//   exit_ack        : one-cycle pulse when an exit is resolved
//   register        : occupancy bitmap [7:1], 1 = occupied
//   available_slots : free slot count
//   can_park        : available_slots != 0
//   gate_open       : barrier drive
//   g_led, r_led    : exit pass / fail lamps
module parking_gate_ctrl
  import parking_pkg::*;
#(
  parameter int unsigned N_ENTRY     = 2,
  parameter int unsigned OPEN_CYCLES = 4
) (
  input  logic               enable,
  input  logic               gl_reset,
  input  logic [N_ENTRY-1:0] entry_req,
  input  logic               exit_req,
  input  logic [2:0]         exit_from,
  input  logic [7:0]         exit_code,
  output logic [N_ENTRY-1:0] entry_gnt,
  output logic [2:0]         slot_id,
  output logic [7:0]         pass_code,
  output logic               exit_ack,
  output logic [NUM_SLOTS:1] register,
  output logic [2:0]         available_slots,
  output logic               can_park,
  output logic               gate_open,
  output logic               g_led,
  output logic               r_led
);

  gate_state_e        r_state, w_state_n;
  logic [3:0]         r_timer, w_timer_n;
  logic [NUM_SLOTS:1] r_occ, w_occ_n;
  logic [2:0]         r_avail, w_avail_n;
  logic               r_can_park, w_can_park_n;
  logic               r_gate, w_gate_n;
  logic               r_gled, w_gled_n;
  logic               r_rled, w_rled_n;
  logic [N_ENTRY-1:0] r_gnt, w_gnt_n;
  logic               r_ack, w_ack_n;
  logic [2:0]         r_slot, w_slot_n;
  logic [7:0]         r_code, w_code_n;
  logic [2:0]         r_xfrom, w_xfrom_n;
  logic [7:0]         r_xcode, w_xcode_n;

  logic [N_ENTRY-1:0] w_arb_gnt;
  logic               w_arb_any;
  logic               w_rr_update;
  logic [2:0]         w_alloc;
  logic               w_exit_pass;

  parking_rr_arb #(
    .N (N_ENTRY)
  ) u_arb (
    .i_clk    (enable),
    .i_rst    (gl_reset),
    .i_req    (entry_req),
    .i_update (w_rr_update),
    .o_gnt    (w_arb_gnt),
    .o_any    (w_arb_any)
  );

  assign w_alloc     = highest_free(r_occ);
  assign w_exit_pass = ((r_occ & slot_mask(r_xfrom)) != '0) &&
                       (r_xcode == slot_code(r_xfrom));

  always_comb begin
    w_state_n   = r_state;
    w_timer_n   = r_timer;
    w_occ_n     = r_occ;
    w_avail_n   = r_avail;
    w_gate_n    = r_gate;
    w_gled_n    = r_gled;
    w_rled_n    = r_rled;
    w_gnt_n     = '0;
    w_ack_n     = 1'b0;
    w_slot_n    = r_slot;
    w_code_n    = r_code;
    w_xfrom_n   = r_xfrom;
    w_xcode_n   = r_xcode;
    w_rr_update = 1'b0;

    unique case (r_state)
      IDLE: begin
        // Exit wins a tie with entry: it can only free capacity.
        if (exit_req) begin
          w_xfrom_n = exit_from;
          w_xcode_n = exit_code;
          w_state_n = EXIT_CHECK;
        end else if (w_arb_any && (r_avail != '0)) begin
          w_occ_n     = r_occ | slot_mask(w_alloc);
          w_avail_n   = r_avail - 3'd1;
          w_gnt_n     = w_arb_gnt;
          w_slot_n    = w_alloc;
          w_code_n    = slot_code(w_alloc);
          w_gled_n    = 1'b0;
          w_rled_n    = 1'b0;
          w_timer_n   = 4'(OPEN_CYCLES);
          w_gate_n    = 1'b1;
          w_rr_update = 1'b1;
          w_state_n   = GATE_OPEN;
        end
      end
      EXIT_CHECK: begin
        // Ack is registered with the result; the requester drops exit_req
        // in the ack cycle, before IDLE samples it again.
        w_ack_n = 1'b1;
        if (w_exit_pass) begin
          w_occ_n   = r_occ & ~slot_mask(r_xfrom);
          w_avail_n = r_avail + 3'd1;
          w_gled_n  = 1'b1;
          w_rled_n  = 1'b0;
          w_timer_n = 4'(OPEN_CYCLES);
          w_gate_n  = 1'b1;
          w_state_n = GATE_OPEN;
        end else begin
          w_gled_n  = 1'b0;
          w_rled_n  = 1'b1;
          w_state_n = IDLE;
        end
      end
      GATE_OPEN: begin
        w_timer_n = r_timer - 4'd1;
        if (w_timer_n == '0) begin
          w_gate_n  = 1'b0;
          w_state_n = IDLE;
        end
      end
      default: w_state_n = IDLE;
    endcase

    w_can_park_n = (w_avail_n != '0);
  end

  always_ff @(posedge enable) begin
    if (gl_reset) begin
      r_state    <= IDLE;
      r_timer    <= '0;
      r_occ      <= '0;
      r_avail    <= 3'(NUM_SLOTS);
      r_can_park <= 1'b1;
      r_gate     <= 1'b0;
      r_gled     <= 1'b0;
      r_rled     <= 1'b0;
      r_gnt      <= '0;
      r_ack      <= 1'b0;
      r_slot     <= '0;
      r_code     <= '0;
      r_xfrom    <= '0;
      r_xcode    <= '0;
    end else begin
      r_state    <= w_state_n;
      r_timer    <= w_timer_n;
      r_occ      <= w_occ_n;
      r_avail    <= w_avail_n;
      r_can_park <= w_can_park_n;
      r_gate     <= w_gate_n;
      r_gled     <= w_gled_n;
      r_rled     <= w_rled_n;
      r_gnt      <= w_gnt_n;
      r_ack      <= w_ack_n;
      r_slot     <= w_slot_n;
      r_code     <= w_code_n;
      r_xfrom    <= w_xfrom_n;
      r_xcode    <= w_xcode_n;
    end
  end

  assign entry_gnt       = r_gnt;
  assign slot_id         = r_slot;
  assign pass_code       = r_code;
  assign exit_ack        = r_ack;
  assign register        = r_occ;
  assign available_slots = r_avail;
  assign can_park        = r_can_park;
  assign gate_open       = r_gate;
  assign g_led           = r_gled;
  assign r_led           = r_rled;

endmodule

// File: doc/parking_gate_ctrl.md
Name: parking_gate_ctrl

Overview:
- Sequences the shared parking barrier and slot pool.
- Arbitrates between several entry lanes and one exit lane.
- Allocates slots and issues per-slot passcodes, validates exit passcodes, and times the barrier.
- Sits between lane sensors/keypads and the slot-occupancy register, which this block owns.

Parameters:
- N_ENTRY, 2, number of entry lanes (1..4).
- OPEN_CYCLES, 4, clock edges the barrier stays open per accepted car (1..15).

Ports:
- enable  in  1  clock, rising edge active.
- gl_reset  in  1  synchronous active-high reset.
- entry_req  in  N_ENTRY  level request per entry lane; held until entry_gnt.
- exit_req  in  1  level exit request; held until exit_ack.
- exit_from  in  3  slot being vacated (1..7).
- exit_code  in  8  passcode keyed at exit.
- entry_gnt  out  N_ENTRY  one-hot, one-cycle grant pulse.
- slot_id  out  3  slot allocated with the current grant.
- pass_code  out  8  passcode for slot_id; valid with entry_gnt, held until the next grant.
- exit_ack  out  1  one-cycle pulse when an exit request is resolved (pass or fail).
- register  out  7  occupancy bitmap [7:1]; 1 = occupied.
- available_slots  out  3  count of free slots, 0..7.
- can_park  out  1  registered: available_slots != 0.
- gate_open  out  1  barrier drive.
- g_led, r_led  out  1  exit result lamps.

Behaviour:
- Reset (sync, overrides everything, including mid-open): state=IDLE, register=0, available_slots=7, can_park=1, gate_open=0, g_led=0, r_led=0, entry_gnt=0, exit_ack=0, slot_id=0, pass_code=0, rr pointer=lane 0.
- Passcode table: code(s) = sum of Fibonacci terms 1,2,3,5,8,13,21,34 taken up to term s+1.
  - Values: 1->3, 2->6, 3->11, 4->19, 5->32, 6->53, 7->87.
  - Slot 0 is invalid.
- Invariant: available_slots == 7 - popcount(register) at every edge.
- FSM states: IDLE, EXIT_CHECK, GATE_OPEN.
- IDLE:
  - exit_req=1: latch exit_from and exit_code, go to EXIT_CHECK. Exit has priority over a same-cycle entry request, because exit frees capacity.
  - Else if entry_req != 0 and available_slots != 0:
    - Round-robin winner starts at the lane after the last granted lane.
    - Allocate the highest-numbered free slot.
    - At the same edge: set the register bit, decrement available_slots, pulse entry_gnt[winner], drive slot_id and pass_code, load timer=OPEN_CYCLES, go to GATE_OPEN.
  - Else if entry_req != 0 and full: no grant, stay IDLE, can_park=0. Requests remain pending.
- EXIT_CHECK (exactly 1 cycle), pulses exit_ack:
  - Pass (register[exit_from]=1, exit_from!=0, code matches): clear the bit, increment the count, g_led=1, r_led=0, load timer, go to GATE_OPEN.
  - Fail (wrong code, empty slot, or slot 0): g_led=0, r_led=1, no state change to the pool, return to IDLE.
- GATE_OPEN:
  - gate_open=1 while timer>0; the timer decrements each edge.
  - On reaching 0: gate_open=0, go to IDLE. IDLE lasts at least one cycle before the next grant.
  - Requests arriving in this state are not serviced until IDLE.
- Lamp hold: g_led and r_led hold until the next exit resolution or reset. An entry grant clears both.
- can_park is updated at every edge from the next-state count.
- Count stays within 0..7; no wrap is possible given the invariant.
- exit_ack and entry_gnt are never asserted in the same cycle.

Decomposition:
- Package parking_pkg holds:
  - state enum {IDLE, EXIT_CHECK, GATE_OPEN}
  - NUM_SLOTS=7
  - the code(s) lookup function/constant array
  - the highest-free-slot priority-encoder function
- One sub-module, parking_rr_arb: N_ENTRY-wide round-robin arbiter with a pointer-update-on-grant input.

Test Plan:
- Reset then single entry on lane 0 -> entry_gnt=01, slot_id=7, pass_code=87, available_slots=6, gate_open high for 4 cycles.
- Lanes 0 and 1 both request continuously, 7 grants -> grants alternate 0,1,0,1…; slots 7..1 allocated; register=7'h7F; available_slots=0; can_park=0; an 8th request is never granted.
- Full lot, exit_from=6, exit_code=53 -> exit_ack, g_led=1, register[6]=0, available_slots=1, can_park=1. Next entry is allocated slot 6 with code 53.
- exit_from=6, exit_code=53 repeated after the slot was vacated -> exit_ack, r_led=1, g_led=0, count unchanged, gate stays closed.
- Same-cycle exit_req (slot 7, code 87) and entry_req in IDLE with a full lot -> exit serviced first; after the gate closes plus 1 IDLE cycle, the entry is granted slot 7.
- gl_reset asserted during GATE_OPEN -> the next edge gives gate_open=0, register=0, available_slots=7, state IDLE.
